// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Per-stage stall/flush decode, deferred PC redirect, stall
//             watchdog and stall-cycle counter for the in-order pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int NSTAGE  = 6,
    parameter int SRC_W   = 3,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_req,
    input  logic [SRC_W-1:0]  flush_src,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              cnt_clr,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              pending,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              timeout
);

    localparam int                 c_RUN_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_RUN_W-1:0] c_TIMEOUT = c_RUN_W'(TIMEOUT);
    localparam logic [SRC_W:0]     c_NSTAGE  = (SRC_W + 1)'(NSTAGE);

    logic                r_pend_valid;
    logic [SRC_W-1:0]    r_pend_src;
    logic [PC_W-1:0]     r_pend_pc;
    logic [c_RUN_W-1:0]  r_run;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any;
    logic [SRC_W-1:0]    w_top;
    logic                w_new_ok;
    logic                w_take_new;
    logic                w_have_cand;
    logic [SRC_W-1:0]    w_cand_src;
    logic [PC_W-1:0]     w_cand_pc;
    logic                w_apply;
    logic [NSTAGE-1:0]   w_stall;
    logic [NSTAGE-1:0]   w_flush;

    assign w_any       = |stall_req;
    assign w_new_ok    = flush_req && (flush_src != '0) && ({1'b0, flush_src} < c_NSTAGE);
    // Older instruction (larger stage index) wins; a tie goes to the new request.
    assign w_take_new  = w_new_ok && (!r_pend_valid || (flush_src >= r_pend_src));
    assign w_have_cand = r_pend_valid || w_new_ok;
    assign w_cand_src  = w_take_new ? flush_src : r_pend_src;
    assign w_cand_pc   = w_take_new ? flush_pc  : r_pend_pc;
    assign w_apply     = w_have_cand && ((stall_req >> w_cand_src) == '0);

    always_comb begin
        w_top   = '0;
        w_stall = '0;
        w_flush = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (stall_req[i]) w_top = SRC_W'(i);
        end
        if (!rst) begin
            if (w_apply) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    w_flush[k] = (k >= 1) && (k < int'(w_cand_src));
                end
            end else if (w_any) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    w_stall[k] = (k <= int'(w_top));
                    w_flush[k] = (k == int'(w_top) + 1);
                end
            end
        end
    end

    assign stall        = w_stall;
    assign flush        = w_flush;
    assign redirect     = !rst && w_apply;
    assign redirect_pc  = (!rst && w_apply) ? w_cand_pc : r_pend_pc;
    assign pending      = r_pend_valid;
    assign stall_cycles = r_cnt;
    assign timeout      = r_timeout;

    // A held redirect is only displaced by a strictly older source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_src   <= '0;
            r_pend_pc    <= '0;
        end else if (w_apply) begin
            r_pend_valid <= 1'b0;
        end else if (w_new_ok && (!r_pend_valid || (flush_src > r_pend_src))) begin
            r_pend_valid <= 1'b1;
            r_pend_src   <= flush_src;
            r_pend_pc    <= flush_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_any) begin
                if (r_run != c_TIMEOUT) r_run <= r_run + 1'b1;
                if (r_run == c_TIMEOUT - 1'b1) r_timeout <= 1'b1;
            end else begin
                r_run <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall[0] && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed and random checks of pipe_hazard_ctrl against a
//             behavioural model of the stall/redirect rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int NS = 6;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_req;
    logic        flush_req;
    logic [2:0]  flush_src;
    logic [31:0] flush_pc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pending;
    logic [31:0] stall_cycles;
    logic        timeout;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NSTAGE (NS),
        .SRC_W  (3),
        .PC_W   (32),
        .CNT_W  (32),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .flush_src   (flush_src),
        .flush_pc    (flush_pc),
        .cnt_clr     (cnt_clr),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pending     (pending),
        .stall_cycles(stall_cycles),
        .timeout     (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit          m_pv;
    int          m_ps;
    logic [31:0] m_pp;
    int          m_run;
    bit          m_to;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [5:0] sr, input logic fr,
                         input logic [2:0] fs, input logic [31:0] fp, input logic cc);
        int          top;
        bit          new_ok, take_new, have, apply;
        int          cs;
        logic [31:0] cp;
        logic [5:0]  e_stall, e_flush;
        bit          e_red;
        rst = r; stall_req = sr; flush_req = fr; flush_src = fs; flush_pc = fp; cnt_clr = cc;
        #4;
        top = -1;
        for (int i = 0; i < NS; i++) if (sr[i]) top = i;
        new_ok   = fr && (int'(fs) >= 1) && (int'(fs) < NS);
        take_new = new_ok && (!m_pv || int'(fs) >= m_ps);
        have     = m_pv || new_ok;
        cs       = take_new ? int'(fs) : m_ps;
        cp       = take_new ? fp : m_pp;
        apply    = have && ((int'(sr) >> cs) == 0);
        e_stall = '0; e_flush = '0; e_red = 1'b0;
        if (!r) begin
            if (apply) begin
                e_red   = 1'b1;
                e_flush = 6'(((1 << cs) - 1) & ~1);
            end else if (top >= 0) begin
                e_stall = 6'((1 << (top + 1)) - 1);
                if (top < NS - 1) e_flush = 6'(1 << (top + 1));
            end
        end
        check("stall", 64'(stall), 64'(e_stall));
        check("flush", 64'(flush), 64'(e_flush));
        check("redirect", 64'(redirect), 64'(e_red));
        if (e_red) check("redirect_pc", 64'(redirect_pc), 64'(cp));
        check("pending", 64'(pending), 64'(m_pv));
        check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        check("timeout", 64'(timeout), 64'(m_to));
        @(posedge clk);
        if (r) begin
            m_pv = 0; m_ps = 0; m_pp = '0; m_run = 0; m_to = 0; m_cnt = '0;
        end else begin
            if (apply) m_pv = 0;
            else if (new_ok && (!m_pv || int'(fs) > m_ps)) begin
                m_pv = 1; m_ps = int'(fs); m_pp = fp;
            end
            if (sr != 0) begin
                m_run = (m_run + 1 > TO) ? TO : m_run + 1;
                if (m_run == TO) m_to = 1;
            end else begin
                m_run = 0;
            end
            if (cc) m_cnt = '0;
            else if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle(input logic [5:0] sr);
        cycle(1'b0, sr, 1'b0, 3'd0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall_req = '0; flush_req = 1'b0; flush_src = '0; flush_pc = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pv = 0; m_ps = 0; m_pp = '0; m_run = 0; m_to = 0; m_cnt = '0;

        // basic decode
        idle(6'b000100);
        idle(6'b000000);
        // immediate redirect
        cycle(1'b0, 6'b0, 1'b1, 3'd3, 32'h80, 1'b0);
        idle(6'b0);
        // deferred redirect behind MEM stall
        cycle(1'b0, 6'b010000, 1'b1, 3'd3, 32'h100, 1'b0);
        idle(6'b010000);
        idle(6'b010000);
        idle(6'b0);
        // older request replaces held one
        cycle(1'b0, 6'b010000, 1'b1, 3'd2, 32'h40, 1'b0);
        cycle(1'b0, 6'b010000, 1'b1, 3'd3, 32'h60, 1'b0);
        idle(6'b0);
        // younger request is dropped
        cycle(1'b0, 6'b010000, 1'b1, 3'd2, 32'h40, 1'b0);
        cycle(1'b0, 6'b010000, 1'b1, 3'd1, 32'h20, 1'b0);
        idle(6'b0);
        // invalid sources ignored
        cycle(1'b0, 6'b0, 1'b1, 3'd0, 32'h99, 1'b0);
        cycle(1'b0, 6'b0, 1'b1, 3'd7, 32'h99, 1'b0);
        // watchdog and counter
        cycle(1'b1, 6'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        repeat (4) idle(6'b000100);
        check("tp_timeout_set", 64'(timeout), 64'd1);
        check("tp_stall_cycles", 64'(stall_cycles), 64'd4);
        idle(6'b0);
        check("tp_timeout_sticky", 64'(timeout), 64'd1);
        cycle(1'b0, 6'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        check("tp_cnt_clr", 64'(stall_cycles), 64'd0);
        cycle(1'b1, 6'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        check("tp_timeout_rst", 64'(timeout), 64'd0);
        // reset during deferral drops the held redirect
        cycle(1'b0, 6'b010000, 1'b1, 3'd3, 32'h200, 1'b0);
        idle(6'b010000);
        cycle(1'b1, 6'b010000, 1'b0, 3'd0, 32'h0, 1'b0);
        check("tp_rst_pending", 64'(pending), 64'd0);
        idle(6'b0);
        idle(6'b0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic        r, fr, cc;
            logic [5:0]  sr;
            logic [2:0]  fs;
            logic [31:0] fp;
            r  = ($urandom_range(0, 59) == 0);
            sr = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'($urandom & 32'h0000_0030);
            if ($urandom_range(0, 3) == 0) sr = '0;
            fr = ($urandom_range(0, 2) == 0);
            fs = 3'($urandom_range(0, 7));
            fp = $urandom;
            cc = ($urandom_range(0, 29) == 0);
            cycle(r, sr, fr, fs, fp, cc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the in-order RISC-V core; successor to the fixed 6-bit stall decoder.
- Takes per-stage stall requests and branch/jump redirect requests.
- Produces per-stage stall and flush vectors plus the PC redirect.
- Defers redirects that cannot apply because of an older-stage stall.
- Adds a stall watchdog and a stall-cycle performance counter.
- Sits beside the pipeline registers; every stage register and the PC register consume its outputs.

Parameters:
NSTAGE, 6, number of pipeline positions; index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
SRC_W, 3, width of the stage-index field; must satisfy 2^SRC_W >= NSTAGE.
PC_W, 32, redirect PC width.
CNT_W, 32, stall performance counter width.
TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires; must be >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high
stall_req  in  NSTAGE  bit i = stage i cannot accept/advance this cycle
flush_req  in  1  redirect request (taken branch/jump resolved)
flush_src  in  SRC_W  stage index resolving the redirect, 1..NSTAGE-1
flush_pc  in  PC_W  redirect target
cnt_clr  in  1  synchronous clear of stall_cycles
stall  out  NSTAGE  bit k = hold pipeline register k
flush  out  NSTAGE  bit k = load bubble into register k this cycle
redirect  out  1  PC loads redirect_pc this cycle
redirect_pc  out  PC_W  target PC
pending  out  1  a deferred redirect is held
stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1
timeout  out  1  sticky watchdog flag

Behaviour:
Reset:
- While rst=1: stall=0, flush=0, redirect=0 (outputs gated combinationally).
- On a clock edge with rst=1: pending store cleared, redirect_pc=0, stall_cycles=0, stall_run=0, timeout=0.
- rst mid-deferral drops the held redirect.

Stall decode (combinational, zero latency):
- top = highest i with stall_req[i]=1.
- stall[k]=1 for all k<=top; stall=0 when stall_req=0.
- flush[top+1]=1 (bubble) when top<NSTAGE-1 and no redirect this cycle.

Redirect candidate:
- Sources: the held pending entry and/or the new flush_req.
- Candidate = the one with the larger src (older instruction wins); tie -> new request.
- flush_src=0 or flush_src>=NSTAGE: the request is ignored.

Redirect apply, with candidate src s:
- Condition: no stall_req[j] for any j>=s.
- redirect=1; redirect_pc = candidate pc (combinational mux of held or input value).
- flush[k]=1 for 1<=k<=s-1.
- stall[k] forced 0 for k<s.
- stall_req below s is ignored this cycle.
- The pending store clears at the edge.

Redirect defer (any stall_req[j], j>=s):
- redirect=0; stall/flush per the normal decode.
- Candidate written into the pending store; pending=1 from the next cycle.
- A later request with src <= held src is dropped; a strictly larger src replaces it.

Watchdog:
- stall_run increments each cycle any stall_req bit is set, clears otherwise, saturates at TIMEOUT.
- timeout sets on the edge where stall_run reaches TIMEOUT; stays set until rst.

stall_cycles:
- +1 per cycle with stall[0]=1, saturating at all-ones.
- cnt_clr has priority over increment; value is 0 the next cycle.

Test Plan:
- NSTAGE=6, stall_req=6'b000100 -> stall=000111, flush=001000, redirect=0; stall_req=0 -> stall=0, flush=0.
- flush_req, src=3, pc=0x80 with no stall -> same cycle: redirect=1, redirect_pc=0x80, flush=000110, stall=0; next cycle pending=0.
- stall_req[4]=1 for 3 cycles with flush_req src=3, pc=0x100 in cycle 1 only:
  - cycles 1-3: redirect=0, stall=011111, pending=1 from cycle 2.
  - cycle 4 (stall released): redirect=1, redirect_pc=0x100, flush=000110.
- Pending src=2, pc=0x40; new request src=3, pc=0x60 arrives while still stalled -> on release redirect_pc=0x60, flush=000110. A new src=1 request while src=2 is held is dropped.
- TIMEOUT=4, stall_req[2] held 4 cycles -> timeout=1 on the 4th edge; stays 1 after stall_req drops; cleared only by rst=1 for 1 cycle. Same run: stall_cycles=4; cnt_clr=1 -> 0 next cycle.
- rst asserted while pending=1 -> next cycle: pending=0, redirect stays 0 after rst drops, stall_cycles=0, timeout=0.
